epp_host: RTL and testbench

- EPP host (initiator) engine: runs address-write, address-read, data-write and data-read cycles on the parallel-port EPP bus toward a peripheral.
- Sits on the FPGA side of a board-to-board link and in the simulation bench that exercises EPP peripherals.
- Takes one command at a time over a valid/ready interface and returns one response per command.
- Times out and recovers cleanly when the peripheral never acknowledges.

---
 rtl/epp_host.sv | 156 +++++++++++++++
 tb/tb_epp_host.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/epp_host.sv
// EPP host engine: runs one EPP address/data read or write cycle per accepted command.
// Latency: 1 + SETUP_CYC + 1 + 2 + 1 + 2 + HOLD_CYC cycles minimum (11 at defaults), more while the peripheral stalls.
// Backpressure: cmd_ready only in IDLE; rsp_valid is a one-cycle pulse with no ready, so the consumer must take it.
module epp_host #(
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int TIMEOUT   = 400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       busy,
    output logic [7:0] pport_dout,
    output logic       pport_oe,
    input  logic [7:0] pport_din,
    output logic       nWrite,
    output logic       nAddrStr,
    output logic       nDataStr,
    input  logic       nWait
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACK, S_RELEASE, S_HOLD} state_t;

    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  wait_sync;
    logic        wait_s;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic [1:0]  op_q;
    logic [7:0]  rd_q;
    logic        to_q;
    logic        op_read;
    logic        op_addr;

    assign wait_s    = wait_sync[1];
    // The phase counter saturates so a stuck phase can never wrap into a false match.
    assign cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    // ops 10/11 are reads; ops 00/11 use the address strobe.
    assign op_read   = op_q[1];
    assign op_addr   = (op_q[0] == op_q[1]);
    assign cmd_ready = (state == S_IDLE) && !reset;
    assign busy      = (state != S_IDLE);

    // nWait is asynchronous to clk: two flops before the FSM looks at it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_sync <= 2'b11;
        end else begin
            wait_sync <= {wait_sync[0], nWait};
        end
    end

    // Bus-cycle sequencer; every bus pin and the response are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= 16'd0;
            op_q        <= 2'b00;
            rd_q        <= 8'h00;
            to_q        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 8'h00;
            rsp_timeout <= 1'b0;
            pport_dout  <= 8'h00;
            pport_oe    <= 1'b0;
            nWrite      <= 1'b1;
            nAddrStr    <= 1'b1;
            nDataStr    <= 1'b1;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_data    <= 8'h00;
            rsp_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q       <= cmd_op;
                        rd_q       <= 8'h00;
                        to_q       <= 1'b0;
                        cnt        <= 16'd0;
                        // Direction and data settle here, well before any strobe.
                        nWrite     <= cmd_op[1];
                        pport_oe   <= ~cmd_op[1];
                        pport_dout <= cmd_op[1] ? 8'h00 : cmd_data;
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt <= 16'd0;
                        if (op_addr) nAddrStr <= 1'b0;
                        else         nDataStr <= 1'b0;
                        state <= S_ACK;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_ACK: begin
                    // An acknowledge on the final allowed cycle still wins over the timeout.
                    if (!wait_s) begin
                        if (op_read) rd_q <= pport_din;
                        nAddrStr <= 1'b1;
                        nDataStr <= 1'b1;
                        cnt      <= 16'd0;
                        state    <= S_RELEASE;
                    end else if (cnt == WAIT_LAST) begin
                        nAddrStr <= 1'b1;
                        nDataStr <= 1'b1;
                        to_q     <= 1'b1;
                        cnt      <= 16'd0;
                        state    <= S_HOLD;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_RELEASE: begin
                    if (wait_s) begin
                        cnt   <= 16'd0;
                        state <= S_HOLD;
                    end else if (cnt == WAIT_LAST) begin
                        to_q  <= 1'b1;
                        cnt   <= 16'd0;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        pport_oe    <= 1'b0;
                        pport_dout  <= 8'h00;
                        nWrite      <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= to_q;
                        rsp_data    <= (op_read && !to_q) ? rd_q : 8'h00;
                        cnt         <= 16'd0;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_epp_host.sv
// Bench for epp_host: directed table, reset and back-to-back sequences, then random commands.
// A behavioural peripheral answers strobes; a monitor logs accepts, strobe pulses and responses.
// Expected results come from hand constants and a phase-time model of the EPP handshake.
module tb_epp_host;
    localparam int SETUP_CYC = 2;
    localparam int HOLD_CYC  = 2;
    localparam int TIMEOUT   = 400;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, rsp_valid, rsp_timeout, busy, pport_oe, nWrite, nAddrStr, nDataStr;
    logic [7:0] rsp_data, pport_dout;
    logic [7:0] pport_din = 8'h00;
    logic       nWait = 1'b1;

    always #5 clk = ~clk;

    epp_host #(.SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .busy(busy), .pport_dout(pport_dout), .pport_oe(pport_oe),
        .pport_din(pport_din), .nWrite(nWrite), .nAddrStr(nAddrStr), .nDataStr(nDataStr),
        .nWait(nWait)
    );

    // mode: 0 normal peripheral, 1 never acknowledges, 2 acknowledges but never releases
    typedef struct {
        logic [1:0] op; logic [7:0] data; int d; int r; int mode; logic [7:0] byt;
        logic [7:0] e_data; logic e_to; int e_lat; int e_slen;
    } vec_t;
    typedef struct { int len; int gap; logic addr; logic nw; logic oe; logic [7:0] dout; } pulse_t;
    typedef struct { logic [7:0] d; logic to; int cyc; } rsp_t;

    int n_chk = 0;
    int n_fail = 0;

    // ---------------- monitor ----------------
    int     cyc = 0;
    pulse_t pulse_a [256];
    rsp_t   rsp_a [256];
    int     acc_a [256];
    int     p_wr = 0, p_rd = 0, r_wr = 0, r_rd = 0, a_wr = 0, a_rd = 0;
    int     proto_err = 0;
    bit     in_pulse = 0;
    bit     prev_rv = 0;
    int     gap = 100000;
    pulse_t cur;
    logic   mon_sl;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        mon_sl = !nAddrStr || !nDataStr;
        if (!nAddrStr && !nDataStr) proto_err++;
        if (rsp_valid && prev_rv) proto_err++;
        prev_rv = rsp_valid;
        if (cmd_valid && cmd_ready) begin
            acc_a[a_wr % 256] = cyc;
            a_wr++;
        end
        if (rsp_valid) begin
            rsp_a[r_wr % 256] = '{rsp_data, rsp_timeout, cyc};
            r_wr++;
        end
        if (mon_sl) begin
            if (!in_pulse) begin
                in_pulse = 1;
                cur.len = 1; cur.gap = gap; cur.addr = !nAddrStr;
                cur.nw = nWrite; cur.oe = pport_oe; cur.dout = pport_dout;
            end else begin
                cur.len++;
                if (nWrite !== cur.nw || pport_oe !== cur.oe || pport_dout !== cur.dout) proto_err++;
            end
        end else if (in_pulse) begin
            pulse_a[p_wr % 256] = cur;
            p_wr++;
            in_pulse = 0;
            gap = 1;
        end else if (gap < 100000) begin
            gap++;
        end
    end

    // ---------------- peripheral model ----------------
    int         p_d = 0, p_r = 0, p_mode = 0;
    logic [7:0] p_byte = 8'h00;
    int         per_gen = 0, seen_gen = 0, pph = 0, pcnt = 0;
    logic       per_sl;

    always @(negedge clk) begin
        per_sl = !nAddrStr || !nDataStr;
        if (per_gen != seen_gen) begin
            seen_gen = per_gen; pph = 0; pcnt = 0; nWait = 1'b1; pport_din = ~p_byte;
        end else if (pph == 0) begin
            if (per_sl && p_mode != 1) begin
                if (pcnt >= p_d) begin
                    nWait = 1'b0; pport_din = p_byte; pph = 1; pcnt = 0;
                end else pcnt++;
            end
        end else begin
            if (!per_sl && p_mode != 2) begin
                if (pcnt >= p_r) begin
                    nWait = 1'b1; pport_din = ~p_byte; pph = 0; pcnt = 0;
                end else pcnt++;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] data, input int d, input int r,
                                input int mode, input logic [7:0] byt, input logic [7:0] e_data,
                                input logic e_to, input int e_lat, input int e_slen);
        vec_t v;
        v.op = op; v.data = data; v.d = d; v.r = r; v.mode = mode; v.byt = byt;
        v.e_data = e_data; v.e_to = e_to; v.e_lat = e_lat; v.e_slen = e_slen;
        return v;
    endfunction

    // Each wait phase completes (delay + 3) cycles after it starts: the peripheral's own
    // delay, two synchroniser cycles and the cycle the engine reacts; past TIMEOUT it aborts.
    function automatic vec_t model(input vec_t v);
        vec_t o;
        int   ack_t, rel_t;
        o = v;
        ack_t = (v.mode == 1) ? TIMEOUT + 1 : v.d + 3;
        rel_t = (v.mode == 2) ? TIMEOUT + 1 : v.r + 3;
        if (ack_t > TIMEOUT) begin
            o.e_to = 1; o.e_data = 8'h00; o.e_slen = TIMEOUT;
            o.e_lat = 1 + SETUP_CYC + TIMEOUT + HOLD_CYC;
        end else if (rel_t > TIMEOUT) begin
            o.e_to = 1; o.e_data = 8'h00; o.e_slen = ack_t;
            o.e_lat = 1 + SETUP_CYC + ack_t + TIMEOUT + HOLD_CYC;
        end else begin
            o.e_to = 0; o.e_data = v.op[1] ? v.byt : 8'h00; o.e_slen = ack_t;
            o.e_lat = 1 + SETUP_CYC + ack_t + rel_t + HOLD_CYC;
        end
        return o;
    endfunction

    task automatic check_pulse(input string nm, input vec_t v, input pulse_t pp);
        chk({nm, ".strobe_len"}, pp.len, v.e_slen);
        chk({nm, ".addr_strobe"}, int'(pp.addr), int'(v.op[0] == v.op[1]));
        chk({nm, ".nWrite"}, int'(pp.nw), int'(v.op[1]));
        chk({nm, ".oe"}, int'(pp.oe), int'(!v.op[1]));
        if (!v.op[1]) chk({nm, ".dout"}, int'(pp.dout), int'(v.data));
    endtask

    task automatic check_rsp(input string nm, input vec_t v, input rsp_t rr, input int ac);
        chk({nm, ".rsp_data"}, int'(rr.d), int'(v.e_data));
        chk({nm, ".rsp_timeout"}, int'(rr.to), int'(v.e_to));
        chk({nm, ".latency"}, rr.cyc - ac, v.e_lat);
    endtask

    task automatic run_cmd(input vec_t v, input string nm);
        bit ok;
        int e0;
        e0 = proto_err;
        p_d = v.d; p_r = v.r; p_mode = v.mode; p_byte = v.byt; per_gen++;
        @(posedge clk); #1;
        cmd_op = v.op; cmd_data = v.data; cmd_valid = 1'b1;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            if (a_wr != a_rd) begin ok = 1; break; end
        end
        #1;
        cmd_valid = 1'b0; cmd_data = 8'($urandom);
        chk({nm, ".accepted"}, int'(ok), 1);
        if (ok) begin
            ok = 0;
            for (int k = 0; k < 2000; k++) begin
                @(posedge clk);
                if (r_wr != r_rd) begin ok = 1; break; end
            end
            chk({nm, ".rsp_seen"}, int'(ok), 1);
            if (ok) begin
                check_rsp(nm, v, rsp_a[r_rd % 256], acc_a[a_rd % 256]);
                chk({nm, ".pulse_count"}, p_wr - p_rd, 1);
                if (p_wr != p_rd) check_pulse(nm, v, pulse_a[p_rd % 256]);
            end
        end
        p_mode = 0; p_r = 0;
        repeat (4) @(posedge clk);
        a_rd = a_wr; r_rd = r_wr; p_rd = p_wr;
        chk({nm, ".protocol"}, proto_err - e0, 0);
    endtask

    initial begin
        vec_t       tv [9];
        vec_t       v;
        vec_t       bb [4];
        logic [1:0] bb_op [4];
        logic [7:0] bb_dat [4];
        int         e0, rc, na;
        bit         ok;

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst.cmd_ready", int'(cmd_ready), 0);
        chk("rst.rsp_valid", int'(rsp_valid), 0);
        chk("rst.rsp_data", int'(rsp_data), 0);
        chk("rst.rsp_timeout", int'(rsp_timeout), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.pport_oe", int'(pport_oe), 0);
        chk("rst.pport_dout", int'(pport_dout), 0);
        chk("rst.nWrite", int'(nWrite), 1);
        chk("rst.nAddrStr", int'(nAddrStr), 1);
        chk("rst.nDataStr", int'(nDataStr), 1);
        reset = 1'b0;
        #1;
        chk("rst.ready_after", int'(cmd_ready), 1);

        // ---- directed table: op, data, ack dly, rel dly, mode, periph byte | data, to, latency, strobe len ----
        tv[0] = mk(2'b00, 8'h05, 3,   0,   0, 8'h00, 8'h00, 1'b0, 14,  6);
        tv[1] = mk(2'b10, 8'h00, 0,   0,   0, 8'hA7, 8'hA7, 1'b0, 11,  3);
        tv[2] = mk(2'b01, 8'h3C, 0,   0,   1, 8'h00, 8'h00, 1'b1, 405, 400);
        tv[3] = mk(2'b11, 8'h00, 1,   0,   2, 8'h44, 8'h00, 1'b1, 409, 4);
        tv[4] = mk(2'b11, 8'h00, 2,   4,   0, 8'h5A, 8'h5A, 1'b0, 17,  5);
        tv[5] = mk(2'b10, 8'h00, 397, 0,   0, 8'hC3, 8'hC3, 1'b0, 408, 400);
        tv[6] = mk(2'b10, 8'h00, 398, 0,   0, 8'h99, 8'h00, 1'b1, 405, 400);
        tv[7] = mk(2'b00, 8'h81, 0,   397, 0, 8'h00, 8'h00, 1'b0, 408, 3);
        tv[8] = mk(2'b01, 8'h7E, 0,   398, 0, 8'h00, 8'h00, 1'b1, 408, 3);
        for (int i = 0; i < 9; i++) run_cmd(tv[i], $sformatf("vec%0d", i));

        // ---- reset during the ACK of a data-write ----
        e0 = proto_err;
        p_mode = 1; p_d = 0; p_r = 0; per_gen++;
        @(posedge clk); #1;
        cmd_op = 2'b01; cmd_data = 8'h55; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst.strobe_low", int'(nDataStr), 0);
        chk("midrst.busy_before", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst.nDataStr", int'(nDataStr), 1);
        chk("midrst.nAddrStr", int'(nAddrStr), 1);
        chk("midrst.pport_oe", int'(pport_oe), 0);
        chk("midrst.nWrite", int'(nWrite), 1);
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.rsp_valid", int'(rsp_valid), 0);
        chk("midrst.cmd_ready", int'(cmd_ready), 0);
        reset = 1'b0;
        rc = r_wr;
        repeat (10) @(posedge clk);
        chk("midrst.no_rsp", r_wr - rc, 0);
        chk("midrst.protocol", proto_err - e0, 0);
        a_rd = a_wr; r_rd = r_wr; p_rd = p_wr;
        p_mode = 0;
        run_cmd(mk(2'b01, 8'hC8, 2, 1, 0, 8'h00, 8'h00, 1'b0, 14, 5), "post_rst");

        // ---- four commands with cmd_valid held high ----
        e0 = proto_err;
        bb_op[0] = 2'b00; bb_dat[0] = 8'h01;
        bb_op[1] = 2'b01; bb_dat[1] = 8'h34;
        bb_op[2] = 2'b01; bb_dat[2] = 8'h12;
        bb_op[3] = 2'b10; bb_dat[3] = 8'hEE;
        p_d = 1; p_r = 2; p_mode = 0; p_byte = 8'h6D; per_gen++;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            bb[i] = model(mk(bb_op[i], bb_dat[i], 1, 2, 0, 8'h6D, 8'h00, 1'b0, 0, 0));
            cmd_op = bb_op[i]; cmd_data = bb_dat[i]; cmd_valid = 1'b1;
            na = a_wr; ok = 0;
            for (int k = 0; k < 100; k++) begin
                @(posedge clk);
                if (a_wr != na) begin ok = 1; break; end
            end
            chk($sformatf("b2b%0d.accepted", i), int'(ok), 1);
            #1;
        end
        cmd_valid = 1'b0;
        ok = 0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            if (r_wr - r_rd >= 4 && p_wr - p_rd >= 4) begin ok = 1; break; end
        end
        chk("b2b.all_rsp", int'(ok), 1);
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                check_rsp($sformatf("b2b%0d", i), bb[i], rsp_a[(r_rd + i) % 256], acc_a[(a_rd + i) % 256]);
                check_pulse($sformatf("b2b%0d", i), bb[i], pulse_a[(p_rd + i) % 256]);
                if (i > 0) chk($sformatf("b2b%0d.gap_ok", i),
                               int'(pulse_a[(p_rd + i) % 256].gap >= SETUP_CYC + HOLD_CYC), 1);
            end
        end
        repeat (4) @(posedge clk);
        chk("b2b.pulse_total", p_wr - p_rd, 4);
        chk("b2b.protocol", proto_err - e0, 0);
        a_rd = a_wr; r_rd = r_wr; p_rd = p_wr;

        // ---- random commands against the phase-time model ----
        for (int i = 0; i < 40; i++) begin
            int m;
            v.op = 2'($urandom_range(0, 3));
            v.data = 8'($urandom);
            v.d = int'($urandom_range(0, 12));
            v.r = int'($urandom_range(0, 12));
            m = int'($urandom_range(0, 9));
            v.mode = (m == 0) ? 1 : (m == 1) ? 2 : 0;
            v.byt = 8'($urandom);
            run_cmd(model(v), $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
